// File: rtl/rr_fifo_push_arbiter_if.sv
// rtl/rr_fifo_push_arbiter_if.sv - master-side request bus and FIFO push bus of the arbiter
interface rr_fifo_push_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        req_i;
    logic [NUM_MASTERS-1:0]        write_i;
    logic [NUM_MASTERS*ADDR_W-1:0] addr_i;
    logic [NUM_MASTERS*DATA_W-1:0] wdata_i;
    logic [NUM_MASTERS-1:0]        gnt_o;

    logic                          push_out;
    logic [ADDR_W-1:0]             push_addr_out;
    logic [DATA_W-1:0]             push_wdata_out;
    logic                          write_out;
    logic                          pop_i;
    logic                          full_i;

    modport master (
        output req_i, write_i, addr_i, wdata_i, pop_i, full_i,
        input  gnt_o, push_out, push_addr_out, push_wdata_out, write_out
    );

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, pop_i, full_i,
        output gnt_o, push_out, push_addr_out, push_wdata_out, write_out
    );
endinterface

// File: rtl/rr_fifo_push_arbiter.sv
// rtl/rr_fifo_push_arbiter.sv - round-robin arbiter feeding one credit-tracked push FIFO
module rr_fifo_push_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    rr_fifo_push_arbiter_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] credits_o,
    output logic                            overflow_err_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [CW-1:0]          r_credits;
    logic [PW-1:0]          r_ptr;
    logic                   r_push;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_write;
    logic                   r_ovf;

    logic                   w_can_grant;
    logic                   w_found;
    int                     w_idx;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [PW-1:0]          w_sel;
    logic [PW-1:0]          w_ptr_next;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic                   w_sel_write;
    logic                   w_grant;
    logic                   w_credits_full;

    assign w_can_grant    = (r_credits != '0) && reset;
    assign w_credits_full = (r_credits == CW'(FIFO_DEPTH));

    // Scan from the priority pointer upward with wrap; first requester wins.
    always_comb begin
        w_gnt       = '0;
        w_sel       = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_idx = (int'(r_ptr) + i) % NUM_MASTERS;
            if (w_can_grant && !w_found && bus.req_i[w_idx]) begin
                w_found       = 1'b1;
                w_gnt[w_idx]  = 1'b1;
                w_sel         = PW'(w_idx);
                w_sel_addr    = bus.addr_i[w_idx*ADDR_W +: ADDR_W];
                w_sel_wdata   = bus.wdata_i[w_idx*DATA_W +: DATA_W];
                w_sel_write   = bus.write_i[w_idx];
            end
        end
    end

    assign w_grant    = w_found;
    assign w_ptr_next = (w_sel == PW'(NUM_MASTERS - 1)) ? '0 : w_sel + PW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_push    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_credits <= CW'(FIFO_DEPTH);
            r_ptr     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_push <= w_grant;
            if (w_grant) begin
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_write <= w_sel_write;
                r_ptr   <= w_ptr_next;
            end
            // A grant and a pop in the same cycle cancel; pops beyond depth are dropped.
            if (w_grant && !bus.pop_i) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_grant && bus.pop_i && !w_credits_full) begin
                r_credits <= r_credits + CW'(1);
            end
            if (r_push && bus.full_i) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.gnt_o          = w_gnt;
    assign bus.push_out       = r_push;
    assign bus.push_addr_out  = r_addr;
    assign bus.push_wdata_out = r_wdata;
    assign bus.write_out      = r_write;
    assign credits_o          = r_credits;
    assign overflow_err_o     = r_ovf;
endmodule

// File: doc/rr_fifo_push_arbiter.md
Name: rr_fifo_push_arbiter

Overview:
- Round-robin arbiter that shares one slave-side push FIFO between NUM_MASTERS requesters.
- Each cycle it selects at most one pending master and acknowledges it with a one-cycle grant.
- The selected master's address, write data and write flag are registered onto the FIFO push interface one cycle later.
- Flow control uses a credit counter that mirrors FIFO occupancy, so a push is never issued into a full FIFO. The block sits between the master-side port mux and the slave FIFO in the interconnect.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.
- FIFO_DEPTH, 8, entry count of the downstream FIFO; also the reset value of the credit counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_i  in  NUM_MASTERS  per-master request, level, held until granted.
- write_i  in  NUM_MASTERS  per-master write(1)/read(0) flag.
- addr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master k occupies bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_MASTERS*DATA_W  packed write data, same packing as addr_i.
- gnt_o  out  NUM_MASTERS  one-hot grant, combinational, asserted in the acceptance cycle.
- push_out  out  1  registered push strobe to the FIFO.
- push_addr_out  out  ADDR_W  registered address of the granted master.
- push_wdata_out  out  DATA_W  registered write data of the granted master.
- write_out  out  1  registered write flag of the granted master.
- pop_i  in  1  copy of the FIFO pop strobe; returns one credit.
- full_i  in  1  FIFO full flag, used only for error checking.
- credits_o  out  $clog2(FIFO_DEPTH+1)  current free-slot count.
- overflow_err_o  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at a clock edge) sets:
  - push_out, write_out, push_addr_out, push_wdata_out to 0;
  - credits to FIFO_DEPTH;
  - the priority pointer to 0, so master 0 has highest priority;
  - overflow_err_o to 0.
- gnt_o is 0 whenever reset==0.
- Arbitration is combinational. can_grant = (credits != 0) && (reset == 1).
  - Search starts at the pointer and moves upward with wrap-around, e.g. pointer=2, N=4: order is 2, 3, 0, 1.
  - The first master with req_i set is granted.
  - If can_grant==0 or no request is pending, gnt_o is all zero.
- On a grant to master k at edge t:
  - push_out=1 during cycle t+1;
  - push_addr_out, push_wdata_out and write_out are captured from master k's inputs at edge t;
  - pointer becomes (k+1) mod NUM_MASTERS.
- With no grant:
  - push_out=0 next cycle;
  - payload registers hold their previous values;
  - the pointer is unchanged.
- Masters drop req_i in the cycle after seeing gnt_o. A request still held after its grant is treated as a new request.
- Credit update per edge, using grant = |gnt_o:
  - grant && !pop_i: credits-1
  - !grant && pop_i: credits+1
  - both or neither: unchanged
- Credit saturation:
  - A pop_i at credits==FIFO_DEPTH is ignored; credits stay at FIFO_DEPTH.
  - Credits never underflow, because grants are blocked at 0.
- Latency: request to grant is 0 cycles when credits are available. Grant to push_out is 1 cycle.
- Throughput: one push per cycle while credits remain. Under continuous requests from all N masters, each master is granted exactly once in every N grants.
- A pop in the same cycle as credits==0 does not enable a grant in that cycle. The grant is issued in the next cycle.
- overflow_err_o is set when push_out==1 && full_i==1. It stays set until reset.
- Reset asserted mid-operation aborts any pending push (push_out=0 next cycle). The FIFO shares the same reset.

Test Plan:
- Single requester: master 2 requests continuously with addr=0x20, wdata=0xA0, write=1 for 8 cycles from reset -> gnt_o=0100 for 8 consecutive cycles; push_out=1 on cycles 1..8 after the first grant with matching payload; credits go 8->0; cycle 9 has no grant.
- Fairness: all 4 masters request continuously, with pops keeping credits > 0 -> grant order 0, 1, 2, 3, 0, 1, …; no master is granted twice before each of the others is granted once.
- Wrap pointer: last grant was master 3, then masters 1 and 3 request -> master 1 is granted first (pointer=0 and master 0 is idle); master 3 is granted next.
- Backpressure: fill to credits=0 with 8 grants, hold req_i[0]=1, pulse pop_i once -> no grant in the pop cycle; one grant in the following cycle; credits return to 0; push_out pulses once.
- Simultaneous grant and pop at credits=3 -> credits stay 3. A pop at credits=8 -> credits stay 8.
- Reset mid-stream: assert reset=0 on the same edge as a grant -> push_out=0 next cycle, credits=8, pointer=0, gnt_o=0 while in reset, overflow_err_o=0. Separately, force full_i=1 during a push -> overflow_err_o=1 and it stays set.
